// File: rtl/data_memory.sv
// Single-port synchronous data memory with post-reset clear sweep and illegal-access flagging.
// Optional per-direction access counters are compiled in with `define DMEM_STATS_EN.
module data_memory #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_cs,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dat_in,
    output logic [31:0] mem_dat_out,
    output logic        mem_rdy,
`ifdef DMEM_STATS_EN
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt,
`endif
    output logic        mem_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e        state_q;
    state_e        state_d;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    logic [DW-1:0] mem_array [DEPTH];

    logic [AW-1:0] idx_c;
    logic          aligned_c;
    logic          in_range_c;
    logic          wr_en_c;
    logic [AW-1:0] wr_idx_c;
    logic [DW-1:0] wr_dat_c;
    logic          rd_en_c;
    logic          illegal_c;
    logic          dout_clr_c;

    assign idx_c      = mem_addr[AW+1:2];
    assign aligned_c  = (mem_addr[1:0] == 2'b00);
    assign in_range_c = (mem_addr[31:AW+2] == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep every word once, then stay in RUN until reset
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Per-cycle controls: sweep write in INIT, qualified access in RUN
    always_comb begin
        wr_en_c    = 1'b0;
        wr_idx_c   = idx_c;
        wr_dat_c   = mem_dat_in;
        rd_en_c    = 1'b0;
        illegal_c  = 1'b0;
        dout_clr_c = 1'b0;
        case (state_q)
            ST_INIT: begin
                wr_en_c    = 1'b1;
                wr_idx_c   = cnt_q;
                wr_dat_c   = '0;
                dout_clr_c = 1'b1;
            end
            ST_RUN: begin
                if (mem_cs) begin
                    if (aligned_c && in_range_c) begin
                        wr_en_c = mem_wen;
                        rd_en_c = !mem_wen;
                    end else begin
                        illegal_c  = 1'b1;
                        dout_clr_c = !mem_wen;
                    end
                end
            end
        endcase
    end

    // Array has no reset; its contents are defined by the sweep
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_array[wr_idx_c] <= wr_dat_c;
        end
    end

    // Registered responder outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_dat_out <= '0;
            mem_rdy     <= 1'b0;
            mem_err     <= 1'b0;
        end else begin
            mem_rdy <= (state_d == ST_RUN);
            mem_err <= illegal_c;
            if (dout_clr_c) begin
                mem_dat_out <= '0;
            end else if (rd_en_c) begin
                mem_dat_out <= mem_array[idx_c];
            end
        end
    end

`ifdef DMEM_STATS_EN
    // Saturating counts of serviced loads and stores
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_en_c && (rd_cnt != '1)) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (wr_en_c && (state_q == ST_RUN) && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed vector table, reset/sweep sequences,
// and randomized accesses compared against an array-based reference model.
module tb_data_memory;

    localparam int unsigned DEPTH = 1024;

    logic        clk;
    logic        rst_n;
    logic        mem_cs;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dat_in;
    logic [31:0] mem_dat_out;
    logic        mem_rdy;
    logic        mem_err;
`ifdef DMEM_STATS_EN
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
`endif

    data_memory #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_cs      (mem_cs),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_dat_in  (mem_dat_in),
        .mem_dat_out (mem_dat_out),
        .mem_rdy     (mem_rdy),
`ifdef DMEM_STATS_EN
        .rd_cnt      (rd_cnt),
        .wr_cnt      (wr_cnt),
`endif
        .mem_err     (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests;
    int unsigned n_fail;

    // Reference model: word array, expected outputs, cycles since reset release
    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_dout;
    logic        exp_err;
    int unsigned cyc;

    typedef struct {
        logic        cs;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] dout;
        logic        err;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock of stimulus; the model applies the access rules at the same edge
    task automatic step(input logic cs, input logic wen, input logic [31:0] addr, input logic [31:0] din);
        logic       was_run;
        logic [9:0] wi;
        mem_cs     = cs;
        mem_wen    = wen;
        mem_addr   = addr;
        mem_dat_in = din;
        was_run    = (cyc >= DEPTH);
        wi         = addr[11:2];
        @(posedge clk);
        if (!was_run) begin
            exp_dout = 32'h0;
            exp_err  = 1'b0;
        end else if (cs) begin
            if ((addr % 4 == 0) && (addr < 4 * DEPTH)) begin
                if (wen) model_mem[wi] = din;
                else     exp_dout = model_mem[wi];
                exp_err = 1'b0;
            end else begin
                exp_err = 1'b1;
                if (!wen) exp_dout = 32'h0;
            end
        end else begin
            exp_err = 1'b0;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        mem_cs = 1'b0;
        rst_n  = 1'b0;
        #2;
        check("rst_rdy", {31'b0, mem_rdy}, 32'h0);
        check("rst_dout", mem_dat_out, 32'h0);
        check("rst_err", {31'b0, mem_err}, 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        cyc      = 0;
        exp_dout = 32'h0;
        exp_err  = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endtask

    // Count cycles until mem_rdy with random requests that must be ignored
    task automatic wait_ready(input string name);
        int unsigned n;
        n = 0;
        while (mem_rdy !== 1'b1 && n < 3000) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h20, $urandom);
            n++;
        end
        check(name, n, DEPTH);
        check({name, "_dout"}, mem_dat_out, 32'h0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int unsigned r;
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        mem_cs     = 1'b0;
        mem_wen    = 1'b0;
        mem_addr   = 32'h0;
        mem_dat_in = 32'h0;
        cyc        = 0;

        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEADBEEF,  32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'h0000_0013, 32'h12345678,  32'hDEADBEEF, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'hDEADBEEF, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_1000, 32'h11111111,  32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_0000, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 32'h0000_0FFC, 32'hCAFEF00D,  32'h0000_0000, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         32'hCAFEF00D, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1'b1};

        do_reset();
        wait_ready("init_sweep");

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].cs, vecs[i].wen, vecs[i].addr, vecs[i].din);
            check($sformatf("vec%0d_dout", i), mem_dat_out, vecs[i].dout);
            check($sformatf("vec%0d_err", i), {31'b0, mem_err}, {31'b0, vecs[i].err});
        end

        // Randomized accesses concentrated on a few regions so loads hit earlier stores
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)       a = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
            else if (r < 7)  a = 32'h0000_0FC0 | {26'b0, 4'($urandom_range(0, 15)), 2'b00};
            else if (r == 7) a = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
            else if (r == 8) a = 32'h0000_1000 + {20'b0, 10'($urandom), 2'b00};
            else             a = $urandom;
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, $urandom);
            check("rand_dout", mem_dat_out, exp_dout);
            check("rand_err", {31'b0, mem_err}, {31'b0, exp_err});
        end
        check("rand_rdy", {31'b0, mem_rdy}, 32'h1);

        // Error pulse lasts exactly one cycle
        step(1'b1, 1'b0, 32'h0000_0001, 32'h0);
        check("err_pulse", {31'b0, mem_err}, 32'h1);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        check("err_drop", {31'b0, mem_err}, 32'h0);

        // Store then reset twice, the second mid-sweep: array must be fully re-cleared
        step(1'b1, 1'b1, 32'h0000_0020, 32'hA5A5A5A5);
        step(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        check("pre_rst_load", mem_dat_out, 32'hA5A5A5A5);
        do_reset();
        for (int i = 0; i < 500; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
        check("mid_sweep_rdy", {31'b0, mem_rdy}, 32'h0);
        do_reset();
        wait_ready("resweep");
`ifdef DMEM_STATS_EN
        check("stats_rd0", rd_cnt, 32'h0);
        check("stats_wr0", wr_cnt, 32'h0);
`endif
        step(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        check("post_rst_load", mem_dat_out, 32'h0);
        check("post_rst_model", mem_dat_out, exp_dout);

`ifdef DMEM_STATS_EN
        step(1'b1, 1'b1, 32'h0000_0040, 32'h1);
        step(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0044, 32'h2);
        step(1'b1, 1'b0, 32'h0000_0046, 32'h0);
        step(1'b1, 1'b0, 32'h0000_0044, 32'h0);
        check("stats_rd", rd_cnt, 32'd3);
        check("stats_wr", wr_cnt, 32'd2);
        force dut.rd_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.rd_cnt;
        step(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        check("stats_sat", rd_cnt, 32'hFFFF_FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
